// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock, RISC-V M-extension semantics
// (div/divu/rem/remu). Divide-by-zero and signed overflow finish in the accepting cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [5:0]       count_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dvs_neg  = is_signed & divisor[WIDTH-1];
    dvd_abs  = dvd_neg ? -dividend : dividend;
    dvs_abs  = dvs_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  end

  // The dividend is shifted out of quo_q into the partial remainder while quotient
  // bits enter at the bottom; the extra top bit of trial is the borrow/sign.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, dvs_q};
    if (!trial[WIDTH+1]) begin
      rem_d = trial[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fin = q_neg_q ? -quo_q : quo_q;
    rem_fin = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              done_q      <= 1'b1;
            end else if (overflow) begin
              quotient_q  <= dividend;
              remainder_q <= '0;
              done_q      <= 1'b1;
            end else begin
              quo_q   <= dvd_abs;
              dvs_q   <= dvs_abs;
              rem_q   <= '0;
              count_q <= '0;
              q_neg_q <= dvd_neg ^ dvs_neg;
              r_neg_q <= dvd_neg;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 6'd1;
          if (count_q == 6'(WIDTH-1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          quotient_q  <= quo_fin;
          remainder_q <= rem_fin;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit; expected results are queued at issue
// time and popped by a monitor whenever done is seen.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && done === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done observed=done expected=no_done");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
      end
      $display("done: quotient=%h remainder=%h", quotient, remainder);
    end
  end

  function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t m;
    if (b == 32'd0) begin
      m.q = 32'hFFFFFFFF;
      m.r = a;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      m.q = 32'h80000000;
      m.r = 32'd0;
    end else if (s) begin
      m.q = $signed(a) / $signed(b);
      m.r = $signed(a) % $signed(b);
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge E0.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eq, input logic [31:0] er);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    if (push) exp_q.push_back(res_t'{q: eq, r: er});
    $display("issue: signed=%0b dividend=%h divisor=%h", s, a, b);
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // k counts edges since E0; busy must stay high until done appears.
  task automatic wait_done(input int k0, output int k, output bit gap);
    k   = k0;
    gap = 1'b0;
    while (k < 45) begin
      if (done === 1'b1) break;
      if (busy !== 1'b1) gap = 1'b1;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_normal(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er);
    int k;
    bit gap;
    issue(s, a, b, 1'b1, eq, er);
    check("done_after_e0", 32'(done), 32'd0);
    wait_done(0, k, gap);
    check("latency", 32'(k), 32'd33);
    check("busy_gap", 32'(gap), 32'd0);
    check("busy_in_done_cycle", 32'(busy), 32'd0);
  endtask

  task automatic run_special(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er);
    issue(s, a, b, 1'b1, eq, er);
    check("special_done", 32'(done), 32'd1);
    check("special_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("special_done_pulse", 32'(done), 32'd0);
    check("special_busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_any(input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t m;
    m = model(s, a, b);
    if (b == 32'd0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF))
      run_special(s, a, b, m.q, m.r);
    else
      run_normal(s, a, b, m.q, m.r);
  endtask

  initial begin
    int k;
    bit gap;
    logic [31:0] ra, rb;
    logic rs;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_normal(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_normal(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run_normal(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    run_normal(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1);
    run_normal(1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF);
    run_normal(1'b1, 32'h80000000, 32'd1, 32'h80000000, 32'd0);
    run_special(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
    run_special(1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
    run_special(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      run_any(rs, ra, rb);
    end

    // A start pulse mid-operation must be ignored.
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    repeat (9) begin
      @(posedge clk); #1;
    end
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10, k, gap);
    check("busy_start_latency", 32'(k), 32'd33);
    check("busy_start_gap", 32'(gap), 32'd0);
    // Start issued inside the done cycle is accepted.
    run_normal(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("no_stray_done", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-CALC discards the operation.
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("rst_no_done", 32'(done), 32'd0);
    check("rst_quotient_held", quotient, 32'd0);
    run_normal(1'b0, 32'd20, 32'd6, 32'd3, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
